// File: rtl/cache_pkg.sv
// cache_pkg: shared cache geometry defaults and line-fill FSM state encoding.
package cache_pkg;
    localparam int WORD_SIZE        = 32;
    localparam int BLOCK_SIZE       = 512;
    localparam int NUM_SEGMENTS     = 16;
    localparam int NUM_SEGMENTS_LOG = 4;
    typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, DONE = 2'd2} lfb_state_t;
endpackage

// File: rtl/line_fill_ctrl.sv
// line_fill_ctrl: fill FSM, beat counter, word-index generation and critical-word pulse.
// LFB_CRITICAL_WORD_FIRST_EN selects a wrapping burst starting at the requested offset.
module line_fill_ctrl
    import cache_pkg::*;
#(
    parameter int N_SEG = 16,
    parameter int N_LOG = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fill_req,
    input  logic [N_LOG-1:0] fill_offset,
    input  logic             mem_rvalid,
    input  logic             blk_ready,
    output logic             mem_rready,
    output logic             fill_busy,
    output logic             blk_valid,
    output logic             beat_we,
    output logic [N_LOG-1:0] beat_idx,
    output logic             crit_hit,
    output logic             crit_valid
);
    lfb_state_t       state_q, state_d;
    logic [N_LOG-1:0] cnt_q, cnt_d;
    logic [N_LOG-1:0] off_q, off_d;
    logic             crit_valid_q;

    assign mem_rready = state_q == FILL;
    assign fill_busy  = state_q != IDLE;
    assign blk_valid  = state_q == DONE;
    assign beat_we    = mem_rready && mem_rvalid;
`ifdef LFB_CRITICAL_WORD_FIRST_EN
    assign beat_idx   = off_q + cnt_q;
`else
    assign beat_idx   = cnt_q;
`endif
    assign crit_hit   = beat_we && beat_idx == off_q;
    assign crit_valid = crit_valid_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        off_d   = off_q;
        if (state_q == IDLE && fill_req) begin
            state_d = FILL;
            cnt_d   = '0;
            off_d   = fill_offset;
        end
        if (beat_we) begin
            cnt_d   = cnt_q + 1'b1;
            state_d = cnt_q == N_LOG'(N_SEG - 1) ? DONE : state_d;
        end
        // fill_req arriving with blk_ready in DONE is deliberately dropped
        if (state_q == DONE && blk_ready) state_d = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            off_q        <= '0;
            crit_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            off_q        <= off_d;
            crit_valid_q <= crit_hit;
        end
    end
endmodule

// File: rtl/line_fill_buffer.sv
// line_fill_buffer: assembles a cache line from memory beats and reports the critical word.
// LFB_CRITICAL_WORD_FIRST_EN (in line_fill_ctrl) selects wrapping critical-word-first order.
module line_fill_buffer #(
    parameter int WORD_SIZE        = cache_pkg::WORD_SIZE,
    parameter int BLOCK_SIZE       = cache_pkg::BLOCK_SIZE,
    parameter int NUM_SEGMENTS     = cache_pkg::NUM_SEGMENTS,
    parameter int NUM_SEGMENTS_LOG = cache_pkg::NUM_SEGMENTS_LOG
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        fill_req,
    input  logic [NUM_SEGMENTS_LOG-1:0] fill_offset,
    output logic                        fill_busy,
    input  logic [WORD_SIZE-1:0]        mem_rdata,
    input  logic                        mem_rvalid,
    output logic                        mem_rready,
    output logic [BLOCK_SIZE-1:0]       blk_data,
    output logic                        blk_valid,
    input  logic                        blk_ready,
    output logic [WORD_SIZE-1:0]        crit_word,
    output logic                        crit_valid
);
    logic                        beat_we, crit_hit;
    logic [NUM_SEGMENTS_LOG-1:0] beat_idx;
    logic [BLOCK_SIZE-1:0]       line_q;
    logic [WORD_SIZE-1:0]        crit_q;

    line_fill_ctrl #(.N_SEG(NUM_SEGMENTS), .N_LOG(NUM_SEGMENTS_LOG)) u_ctrl (
        .clk        (clk),
        .rst        (rst),
        .fill_req   (fill_req),
        .fill_offset(fill_offset),
        .mem_rvalid (mem_rvalid),
        .blk_ready  (blk_ready),
        .mem_rready (mem_rready),
        .fill_busy  (fill_busy),
        .blk_valid  (blk_valid),
        .beat_we    (beat_we),
        .beat_idx   (beat_idx),
        .crit_hit   (crit_hit),
        .crit_valid (crit_valid)
    );

    assign blk_data  = line_q;
    assign crit_word = crit_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_q <= '0;
            crit_q <= '0;
        end else begin
            if (beat_we) line_q[beat_idx*WORD_SIZE +: WORD_SIZE] <= mem_rdata;
            if (crit_hit) crit_q <= mem_rdata;
        end
    end
endmodule

// File: tb/tb_line_fill_buffer.sv
// tb_line_fill_buffer: scoreboard bench for line_fill_buffer (linear or wrapping build).
module tb_line_fill_buffer;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         fill_req = 1'b0;
    logic [3:0]   fill_offset = '0;
    logic         fill_busy;
    logic [31:0]  mem_rdata = '0;
    logic         mem_rvalid = 1'b0;
    logic         mem_rready;
    logic [511:0] blk_data;
    logic         blk_valid;
    logic         blk_ready = 1'b0;
    logic [31:0]  crit_word;
    logic         crit_valid;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_q[$];
    logic [31:0] crit_exp_q[$];

    line_fill_buffer dut (
        .clk(clk), .rst(rst), .fill_req(fill_req), .fill_offset(fill_offset),
        .fill_busy(fill_busy), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .mem_rready(mem_rready), .blk_data(blk_data), .blk_valid(blk_valid),
        .blk_ready(blk_ready), .crit_word(crit_word), .crit_valid(crit_valid)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] idx_of(input logic [3:0] off, input int k);
`ifdef LFB_CRITICAL_WORD_FIRST_EN
        return off + 4'(k);
`else
        return 4'(k);
`endif
    endfunction

    // Drives a fill of nbeats beats (base+k); returns FILL-phase cycles spent.
    task automatic run_fill(input logic [3:0] off, input logic [31:0] base, input bit stall,
                            input int nbeats, output int cycles);
        logic [31:0] line [16];
        int k = 0;
        int pulses = 0;
        for (int i = 0; i < 16; i++) line[i] = 'x;
        for (int j = 0; j < 16; j++) begin
            line[idx_of(off, j)] = base + 32'(j);
            if (idx_of(off, j) == off && j < nbeats) crit_exp_q.push_back(base + 32'(j));
        end
        if (nbeats == 16) for (int i = 0; i < 16; i++) exp_q.push_back(line[i]);
        fill_req = 1'b1;
        fill_offset = off;
        tick();
        fill_req = 1'b0;
        cycles = 0;
        tests++;
        if (fill_busy !== 1'b1 || mem_rready !== 1'b1) begin
            fails++;
            $display("FAIL fill_start: busy=%b rready=%b want 1 1", fill_busy, mem_rready);
        end
        while (k < nbeats && cycles < 200) begin
            mem_rvalid = stall ? cycles % 2 == 1 : 1'b1;
            mem_rdata = base + 32'(k);
            tick();
            if (mem_rvalid) k++;
            cycles++;
            if (crit_valid) begin
                pulses++;
                tests++;
                if (crit_exp_q.size() == 0 || crit_word !== crit_exp_q[0]) begin
                    fails++;
                    $display("FAIL crit_word: got %h want %h", crit_word,
                             crit_exp_q.size() ? crit_exp_q[0] : 32'hx);
                end
                if (crit_exp_q.size()) void'(crit_exp_q.pop_front());
            end
        end
        mem_rvalid = 1'b0;
        tests++;
        if (k != nbeats || pulses != 1) begin
            fails++;
            $display("FAIL fill_beats: beats=%0d pulses=%0d want %0d 1", k, pulses, nbeats);
        end
        if (nbeats == 16) begin
            tests++;
            if (blk_valid !== 1'b1 || fill_busy !== 1'b1 || mem_rready !== 1'b0) begin
                fails++;
                $display("FAIL done_state: valid=%b busy=%b rready=%b want 1 1 0",
                         blk_valid, fill_busy, mem_rready);
            end
        end
    endtask

    task automatic check_line(input string name);
        for (int i = 0; i < 16; i++) begin
            logic [31:0] e;
            e = exp_q.size() ? exp_q.pop_front() : 32'hx;
            tests++;
            if (blk_data[i*32 +: 32] !== e) begin
                fails++;
                $display("FAIL %s word%0d: got %h want %h", name, i, blk_data[i*32 +: 32], e);
            end
        end
    endtask

    task automatic consume;
        blk_ready = 1'b1;
        tick();
        blk_ready = 1'b0;
        tests++;
        if (blk_valid !== 1'b0 || fill_busy !== 1'b0) begin
            fails++;
            $display("FAIL consume: valid=%b busy=%b want 0 0", blk_valid, fill_busy);
        end
    endtask

    task automatic test_reset;
        #2;
        tests++;
        if ({fill_busy, mem_rready, blk_valid, crit_valid, crit_word, blk_data} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: busy=%b rready=%b valid=%b cv=%b cw=%h",
                     fill_busy, mem_rready, blk_valid, crit_valid, crit_word);
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_linear;
        int c;
        run_fill(4'd0, 32'h1000, 1'b0, 16, c);
        tests++;
        if (c + 1 != 17) begin
            fails++;
            $display("FAIL linear_latency: got %0d want 17", c + 1);
        end
        check_line("linear");
        tests++;
        if (crit_word !== 32'h1000) begin
            fails++;
            $display("FAIL linear_crit: got %h want 00001000", crit_word);
        end
        consume();
    endtask

    task automatic test_stalls;
        int c;
        run_fill(4'd0, 32'h1000, 1'b1, 16, c);
        tests++;
        if (c != 32) begin
            fails++;
            $display("FAIL stall_latency: got %0d want 32", c);
        end
        check_line("stalls");
        consume();
    endtask

    task automatic test_backpressure;
        int c;
        logic [511:0] held;
        run_fill(4'd9, 32'h5000, 1'b0, 16, c);
        held = blk_data;
        check_line("bp");
        for (int i = 0; i < 5; i++) begin
            fill_req = i == 2;
            mem_rvalid = 1'b1;
            tick();
            tests++;
            if (blk_valid !== 1'b1 || blk_data !== held || mem_rready !== 1'b0) begin
                fails++;
                $display("FAIL bp_hold cyc%0d: valid=%b rready=%b data_same=%b",
                         i, blk_valid, mem_rready, blk_data === held);
            end
        end
        mem_rvalid = 1'b0;
        fill_req = 1'b1;
        consume();
        fill_req = 1'b0;
        tick();
        tests++;
        if (fill_busy !== 1'b0) begin
            fails++;
            $display("FAIL bp_req_dropped: busy=%b want 0", fill_busy);
        end
    endtask

    task automatic test_critical_word;
        int c;
        run_fill(4'd5, 32'hA0, 1'b0, 16, c);
        check_line("crit");
        tests++;
`ifdef LFB_CRITICAL_WORD_FIRST_EN
        if (crit_word !== 32'hA0) begin
`else
        if (crit_word !== 32'hA5) begin
`endif
            fails++;
            $display("FAIL crit_final: got %h", crit_word);
        end
        consume();
    endtask

    task automatic test_reset_mid_fill;
        int c;
        run_fill(4'd3, 32'hDEAD0000, 1'b0, 7, c);
        rst = 1'b1;
        #2;
        tests++;
        if ({fill_busy, mem_rready, blk_valid, crit_valid, crit_word, blk_data} !== '0) begin
            fails++;
            $display("FAIL midreset_outputs: busy=%b valid=%b cw=%h data_nz=%b",
                     fill_busy, blk_valid, crit_word, |blk_data);
        end
        exp_q.delete();
        crit_exp_q.delete();
        tick();
        rst = 1'b0;
        tick();
        run_fill(4'd0, 32'h7700, 1'b0, 16, c);
        check_line("after_reset");
        consume();
    endtask

    task automatic test_wrap;
`ifdef LFB_CRITICAL_WORD_FIRST_EN
        int c;
        run_fill(4'd15, 32'hC0, 1'b0, 16, c);
        tests++;
        if (blk_data[15*32 +: 32] !== 32'hC0 || blk_data[31:0] !== 32'hC1 ||
            blk_data[14*32 +: 32] !== 32'hCF) begin
            fails++;
            $display("FAIL wrap: w15=%h w0=%h w14=%h want c0 c1 cf",
                     blk_data[15*32 +: 32], blk_data[31:0], blk_data[14*32 +: 32]);
        end
        check_line("wrap");
        consume();
`endif
    endtask

    initial begin
        test_reset();
        test_linear();
        test_stalls();
        test_backpressure();
        test_critical_word();
        test_reset_mid_fill();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
